// File: rtl/apb_queued_requester.sv
// APB4 requester: queues local commands, issues them as back-to-back APB transfers with a
// bounded wait-state timeout, and returns status through a response FIFO.
module apb_queued_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [2:0]                    pprot,
  output logic                          pnse,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH/8-1:0]       pstrb,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]       cmd_strb,
  input  logic [2:0]                    cmd_prot,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic [$clog2(DEPTH+1)-1:0]    cmd_level,
  output logic                          busy
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_LVL  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ROOM_LVL  = CW'(DEPTH - 2);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
    logic [2:0]            prot;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  cmd_t            cmd_mem [DEPTH];
  logic [PW-1:0]   cmd_wr_ptr, cmd_rd_ptr;
  logic [CW-1:0]   cmd_count, cmd_count_next;
  rsp_t            rsp_mem [DEPTH];
  logic [PW-1:0]   rsp_wr_ptr, rsp_rd_ptr;
  logic [CW-1:0]   rsp_count;

  state_t          state, state_next;
  logic [TW-1:0]   wait_cnt;
  logic            cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic            timeout_hit, done, rsp_room;
  cmd_t            cmd_in, cmd_head;
  rsp_t            rsp_in;

  assign cmd_in   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                      strb: cmd_strb, prot: cmd_prot};
  assign cmd_head = cmd_mem[cmd_rd_ptr];

  assign cmd_ready   = (cmd_count != FULL_LVL);
  assign cmd_push    = cmd_valid & cmd_ready;
  assign cmd_level   = cmd_count;
  assign rsp_valid   = (rsp_count != '0);
  assign rsp_pop     = rsp_valid & rsp_ready;
  assign rsp_rdata   = rsp_mem[rsp_rd_ptr].rdata;
  assign rsp_err     = rsp_mem[rsp_rd_ptr].err;
  assign rsp_timeout = rsp_mem[rsp_rd_ptr].timeout;
  assign pnse        = 1'b0;

  assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !pready && (wait_cnt == WAIT_LAST);
  assign done        = (state == ACCESS) && (pready || timeout_hit);
  // Room for the next transfer's response, counting the push that happens on this edge.
  assign rsp_room    = (rsp_count <= ROOM_LVL) || ((rsp_count == LAST_LVL) && rsp_pop);

  assign rsp_in = '{rdata:   (timeout_hit || pwrite) ? '0 : prdata,
                    err:     pslverr | timeout_hit,
                    timeout: timeout_hit};

  assign cmd_count_next = cmd_count + CW'(cmd_push) - CW'(cmd_pop);

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_pop    = 1'b0;
    rsp_push   = 1'b0;
    case (state)
      IDLE: begin
        if ((cmd_count != '0) && (rsp_count != FULL_LVL)) begin
          state_next = SETUP;
          cmd_pop    = 1'b1;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (done) begin
          rsp_push = 1'b1;
          if ((cmd_count != '0) && rsp_room) begin
            state_next = SETUP;
            cmd_pop    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the FIFO storage is reset as well; it is tiny, and clearing it keeps the
  // rsp_* outputs (read straight from storage) at 0 after reset.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
      for (int i = 0; i < DEPTH; i++) cmd_mem[i] <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wr_ptr] <= cmd_in;
        cmd_wr_ptr          <= cmd_wr_ptr + PW'(1);
      end
      if (cmd_pop) cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
      cmd_count <= cmd_count_next;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
      for (int i = 0; i < DEPTH; i++) rsp_mem[i] <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem[rsp_wr_ptr] <= rsp_in;
        rsp_wr_ptr          <= rsp_wr_ptr + PW'(1);
      end
      if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + PW'(1);
      rsp_count <= rsp_count + CW'(rsp_push) - CW'(rsp_pop);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
    end else if (cmd_pop) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= cmd_head.write;
      paddr   <= cmd_head.addr;
      pwdata  <= cmd_head.wdata;
      pstrb   <= cmd_head.write ? cmd_head.strb : '0;
      pprot   <= cmd_head.prot;
    end else if (state == SETUP) begin
      penable <= 1'b1;
    end else if (done) begin
      // pwdata and pprot intentionally keep their last values while idle.
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pstrb   <= '0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      if (state == SETUP)                  wait_cnt <= '0;
      else if ((state == ACCESS) && !pready) wait_cnt <= wait_cnt + TW'(1);
      busy <= (state_next != IDLE) || (cmd_count_next != '0);
    end
  end

endmodule
